// File: rtl/axi_chan_checker_if.sv
// rtl/axi_chan_checker_if.sv - observed five-channel AXI bus at ports A and B
// Channel index in every 5-bit vector: 0=AW 1=W 2=B 3=AR 4=R.
// Signals:
//   a_valid/a_ready, b_valid/b_ready   per-channel handshakes at port A / port B
//   a_aw..a_r, b_aw..b_r               packed channel payloads at port A / port B
// Modports:
//   master  drives every signal (the bus under observation)
//   slave   samples every signal (the passive checker)
interface axi_chan_checker_if #(
    parameter int AwWidth = 64,
    parameter int WWidth  = 73,
    parameter int BWidth  = 6,
    parameter int ArWidth = 64,
    parameter int RWidth  = 71
) ();
    logic [4:0]         a_valid;
    logic [4:0]         a_ready;
    logic [4:0]         b_valid;
    logic [4:0]         b_ready;
    logic [AwWidth-1:0] a_aw;
    logic [WWidth-1:0]  a_w;
    logic [BWidth-1:0]  a_b;
    logic [ArWidth-1:0] a_ar;
    logic [RWidth-1:0]  a_r;
    logic [AwWidth-1:0] b_aw;
    logic [WWidth-1:0]  b_w;
    logic [BWidth-1:0]  b_b;
    logic [ArWidth-1:0] b_ar;
    logic [RWidth-1:0]  b_r;

    modport master (
        output a_valid, a_ready, b_valid, b_ready,
        output a_aw, a_w, a_b, a_ar, a_r,
        output b_aw, b_w, b_b, b_ar, b_r
    );

    modport slave (
        input a_valid, a_ready, b_valid, b_ready,
        input a_aw, a_w, a_b, a_ar, a_r,
        input b_aw, b_w, b_b, b_ar, b_r
    );
endinterface

// File: rtl/axi_chan_checker.sv
// rtl/axi_chan_checker.sv - passive in-order checker of five AXI channels between ports A and B
// Ports:
//   clk              clock, all sampling on the rising edge
//   rst              asynchronous active-high reset
//   bus              observed A/B handshakes and payloads (slave modport)
//   mismatch         one-cycle pulse per channel, cycle after a failing sink beat
//   mismatch_sticky  sticky OR of mismatch
//   overflow         sticky, source beat dropped because the channel FIFO was full
//   unexpected       sticky, sink beat with nothing expected
//   pending          channel FIFO non-empty
//   idle             all channel FIFOs empty
// Channel index: 0=AW 1=W 2=B 3=AR 4=R. AW/W/AR travel A->B, B/R travel B->A.
module axi_chan_checker #(
    parameter int IdWidth  = 4,
    parameter int AwWidth  = 64,
    parameter int WWidth   = 73,
    parameter int BWidth   = 6,
    parameter int ArWidth  = 64,
    parameter int RWidth   = 71,
    parameter int Depth    = 8,
    parameter int IgnoreId = 1
) (
    input  logic                clk,
    input  logic                rst,
    axi_chan_checker_if.slave   bus,
    output logic [4:0]          mismatch,
    output logic [4:0]          mismatch_sticky,
    output logic [4:0]          overflow,
    output logic [4:0]          unexpected,
    output logic [4:0]          pending,
    output logic                idle
);

    // Every channel is carried at the widest payload width; unused upper
    // bits are constant zero on both sides and never cause a mismatch.
    localparam int Max01 = (AwWidth > WWidth) ? AwWidth : WWidth;
    localparam int Max23 = (BWidth > ArWidth) ? BWidth : ArWidth;
    localparam int Max03 = (Max01 > Max23) ? Max01 : Max23;
    localparam int MaxW  = (Max03 > RWidth) ? Max03 : RWidth;
    localparam int PtrW  = $clog2(Depth);

    // Response channels (B, R) have their source at port B.
    localparam logic [4:0] RespCh = 5'b10100;

    logic [4:0]      a_fire;
    logic [4:0]      b_fire;
    logic [4:0]      src_fire;
    logic [4:0]      snk_fire;
    logic [MaxW-1:0] a_pay   [5];
    logic [MaxW-1:0] b_pay   [5];
    logic [MaxW-1:0] src_pay [5];
    logic [MaxW-1:0] snk_pay [5];

    assign a_fire   = bus.a_valid & bus.a_ready;
    assign b_fire   = bus.b_valid & bus.b_ready;
    assign src_fire = (a_fire & ~RespCh) | (b_fire & RespCh);
    assign snk_fire = (b_fire & ~RespCh) | (a_fire & RespCh);

    always_comb begin
        a_pay[0] = MaxW'(bus.a_aw);
        a_pay[1] = MaxW'(bus.a_w);
        a_pay[2] = MaxW'(bus.a_b);
        a_pay[3] = MaxW'(bus.a_ar);
        a_pay[4] = MaxW'(bus.a_r);
        b_pay[0] = MaxW'(bus.b_aw);
        b_pay[1] = MaxW'(bus.b_w);
        b_pay[2] = MaxW'(bus.b_b);
        b_pay[3] = MaxW'(bus.b_ar);
        b_pay[4] = MaxW'(bus.b_r);
        // W has no ID field, so it is always compared in full.
        if (IgnoreId != 0) begin
            for (int c = 0; c < 5; c++) begin
                if (c != 1) begin
                    a_pay[c][IdWidth-1:0] = '0;
                    b_pay[c][IdWidth-1:0] = '0;
                end
            end
        end
        for (int c = 0; c < 5; c++) begin
            src_pay[c] = RespCh[c] ? b_pay[c] : a_pay[c];
            snk_pay[c] = RespCh[c] ? a_pay[c] : b_pay[c];
        end
    end

    for (genvar c = 0; c < 5; c++) begin : g_ch
        logic [MaxW-1:0] mem [Depth];
        logic [MaxW-1:0] head;
        logic [PtrW-1:0] rd_ptr;
        logic [PtrW-1:0] wr_ptr;
        logic [PtrW:0]   count;
        logic            empty;
        logic            full;
        logic            push;
        logic            pop;
        logic            bad;
        logic            unexp;
        logic            ovf;
        logic            mm_q;
        logic            st_q;
        logic            ov_q;
        logic            un_q;

        assign empty = (count == '0);
        // Depth is a power of two and count never exceeds it, so the MSB alone means full.
        assign full  = count[PtrW];
        assign head  = mem[rd_ptr];

        // A sink beat meeting an empty FIFO consumes the simultaneous source
        // beat directly, so that beat is never stored.
        assign pop   = snk_fire[c] & ~empty;
        assign push  = src_fire[c] & ~(snk_fire[c] & empty) & (~full | snk_fire[c]);
        assign unexp = snk_fire[c] & empty & ~src_fire[c];
        assign ovf   = src_fire[c] & full & ~snk_fire[c];
        assign bad   = snk_fire[c] & (empty ? (~src_fire[c] | (snk_pay[c] != src_pay[c]))
                                            : (snk_pay[c] != head));

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= src_pay[c];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                mm_q   <= 1'b0;
                st_q   <= 1'b0;
                ov_q   <= 1'b0;
                un_q   <= 1'b0;
            end else begin
                mm_q <= bad;
                if (bad) begin
                    st_q <= 1'b1;
                end
                if (ovf) begin
                    ov_q <= 1'b1;
                end
                if (unexp) begin
                    un_q <= 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        assign mismatch[c]        = mm_q;
        assign mismatch_sticky[c] = st_q;
        assign overflow[c]        = ov_q;
        assign unexpected[c]      = un_q;
        assign pending[c]         = ~empty;
    end

    assign idle = ~|pending;

endmodule

// File: tb/tb_axi_chan_checker.sv
// tb/tb_axi_chan_checker.sv - self-checking bench for axi_chan_checker
module tb_axi_chan_checker;

    localparam int Depth = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_chan_checker_if bus_if ();

    logic [4:0] mm0, st0, ov0, un0, pd0;
    logic       id0;
    logic [4:0] mm1, st1, ov1, un1, pd1;
    logic       id1;

    axi_chan_checker #(.IgnoreId(1), .Depth(Depth)) dut0 (
        .clk(clk), .rst(rst), .bus(bus_if),
        .mismatch(mm0), .mismatch_sticky(st0), .overflow(ov0),
        .unexpected(un0), .pending(pd0), .idle(id0)
    );

    axi_chan_checker #(.IgnoreId(0), .Depth(Depth)) dut1 (
        .clk(clk), .rst(rst), .bus(bus_if),
        .mismatch(mm1), .mismatch_sticky(st1), .overflow(ov1),
        .unexpected(un1), .pending(pd1), .idle(id1)
    );

    int total = 0;
    int bad   = 0;

    logic [4:0]  av, ar, bv, br;
    logic [79:0] apv [5];
    logic [79:0] bpv [5];

    // Reference model: per DUT (k) and channel, a queue of expected beats.
    logic [79:0] q [10][$];
    logic [4:0]  e_mm [2];
    logic [4:0]  e_st [2];
    logic [4:0]  e_ov [2];
    logic [4:0]  e_un [2];

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int chw(input int ch);
        case (ch)
            0:       return 64;
            1:       return 73;
            2:       return 6;
            3:       return 64;
            default: return 71;
        endcase
    endfunction

    function automatic logic [79:0] norm(input int ch, input logic [79:0] v, input bit ign);
        logic [79:0] r;
        r = v & ((80'd1 << chw(ch)) - 80'd1);
        if (ign && ch != 1) r[3:0] = 4'h0;
        return r;
    endfunction

    task automatic apply();
        bus_if.a_valid = av;
        bus_if.a_ready = ar;
        bus_if.b_valid = bv;
        bus_if.b_ready = br;
        bus_if.a_aw = apv[0][63:0];
        bus_if.a_w  = apv[1][72:0];
        bus_if.a_b  = apv[2][5:0];
        bus_if.a_ar = apv[3][63:0];
        bus_if.a_r  = apv[4][70:0];
        bus_if.b_aw = bpv[0][63:0];
        bus_if.b_w  = bpv[1][72:0];
        bus_if.b_b  = bpv[2][5:0];
        bus_if.b_ar = bpv[3][63:0];
        bus_if.b_r  = bpv[4][70:0];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) q[i].delete();
        for (int k = 0; k < 2; k++) begin
            e_mm[k] = '0; e_st[k] = '0; e_ov[k] = '0; e_un[k] = '0;
        end
    endtask

    // Apply the rules to the beats that will be seen at the coming edge.
    task automatic model_fire();
        bit          resp, sf, kf;
        logic [79:0] sd, kd, hd;
        int          idx;
        for (int k = 0; k < 2; k++) begin
            for (int ch = 0; ch < 5; ch++) begin
                resp = (ch == 2 || ch == 4);
                sf = resp ? (bv[ch] & br[ch]) : (av[ch] & ar[ch]);
                kf = resp ? (av[ch] & ar[ch]) : (bv[ch] & br[ch]);
                sd = norm(ch, resp ? bpv[ch] : apv[ch], k == 0);
                kd = norm(ch, resp ? apv[ch] : bpv[ch], k == 0);
                idx = k * 5 + ch;
                e_mm[k][ch] = 1'b0;
                if (kf) begin
                    if (q[idx].size() == 0) begin
                        if (sf) e_mm[k][ch] = (kd != sd);
                        else begin
                            e_mm[k][ch] = 1'b1;
                            e_un[k][ch] = 1'b1;
                        end
                    end else begin
                        hd = q[idx].pop_front();
                        e_mm[k][ch] = (hd != kd);
                        if (sf) q[idx].push_back(sd);
                    end
                end else if (sf) begin
                    if (q[idx].size() >= Depth) e_ov[k][ch] = 1'b1;
                    else q[idx].push_back(sd);
                end
                if (e_mm[k][ch]) e_st[k][ch] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        logic [4:0] ep;
        for (int k = 0; k < 2; k++) begin
            ep = '0;
            for (int ch = 0; ch < 5; ch++) ep[ch] = (q[k*5+ch].size() != 0);
            check($sformatf("d%0d mismatch", k), k == 0 ? mm0 : mm1, e_mm[k]);
            check($sformatf("d%0d sticky", k), k == 0 ? st0 : st1, e_st[k]);
            check($sformatf("d%0d overflow", k), k == 0 ? ov0 : ov1, e_ov[k]);
            check($sformatf("d%0d unexpected", k), k == 0 ? un0 : un1, e_un[k]);
            check($sformatf("d%0d pending", k), k == 0 ? pd0 : pd1, ep);
            check($sformatf("d%0d idle", k), {4'b0, (k == 0 ? id0 : id1)}, {4'b0, (ep == 5'b0)});
        end
    endtask

    task automatic step();
        apply();
        model_fire();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic clear_inputs();
        av = '0; ar = '0; bv = '0; br = '0;
        for (int ch = 0; ch < 5; ch++) begin
            apv[ch] = '0;
            bpv[ch] = '0;
        end
        apply();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset pending", pd0, 5'b0);
        check("reset idle", {4'b0, id0}, 5'b00001);
        check("reset sticky", st1 | ov1 | un1 | mm1, 5'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0] av, ar, bv, br;
        logic [3:0] aid, bid;
        logic [4:0] e_mm0, e_mm1, e_pd, e_un;
    } vec_t;

    vec_t        tbl [11];
    logic [79:0] base;
    logic [31:0] r0, r1, r2;
    logic [79:0] src, snk;

    initial begin
        base = 80'h0000_0000_DEAD_BEEF_1000;
        //               av        ar        bv        br       aid bid  mm0       mm1       pend      unexp
        tbl[0]  = '{5'b00001, 5'b00001, 5'b00000, 5'b00000, 4'd3, 4'd0, 5'b00000, 5'b00000, 5'b00001, 5'b00000};
        tbl[1]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'd3, 4'd0, 5'b00000, 5'b00000, 5'b00001, 5'b00000};
        tbl[2]  = '{5'b00000, 5'b00000, 5'b00001, 5'b00001, 4'd3, 4'd7, 5'b00000, 5'b00001, 5'b00000, 5'b00000};
        tbl[3]  = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 4'd5, 4'd5, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tbl[4]  = '{5'b00100, 5'b00100, 5'b00000, 5'b00000, 4'd2, 4'd0, 5'b00100, 5'b00100, 5'b00000, 5'b00100};
        tbl[5]  = '{5'b01000, 5'b00000, 5'b00000, 5'b00000, 4'd1, 4'd0, 5'b00000, 5'b00000, 5'b00000, 5'b00100};
        tbl[6]  = '{5'b01000, 5'b01000, 5'b00000, 5'b00000, 4'd1, 4'd0, 5'b00000, 5'b00000, 5'b01000, 5'b00100};
        tbl[7]  = '{5'b00000, 5'b00000, 5'b01000, 5'b00000, 4'd0, 4'd1, 5'b00000, 5'b00000, 5'b01000, 5'b00100};
        tbl[8]  = '{5'b00000, 5'b00000, 5'b01000, 5'b01000, 4'd0, 4'd1, 5'b00000, 5'b00000, 5'b00000, 5'b00100};
        tbl[9]  = '{5'b00010, 5'b00010, 5'b00000, 5'b00000, 4'd2, 4'd0, 5'b00000, 5'b00000, 5'b00010, 5'b00100};
        tbl[10] = '{5'b00000, 5'b00000, 5'b00010, 5'b00010, 4'd0, 4'd3, 5'b00010, 5'b00010, 5'b00000, 5'b00100};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            av = tbl[i].av; ar = tbl[i].ar; bv = tbl[i].bv; br = tbl[i].br;
            for (int ch = 0; ch < 5; ch++) begin
                apv[ch] = base | 80'(tbl[i].aid);
                bpv[ch] = base | 80'(tbl[i].bid);
            end
            step();
            check($sformatf("tbl%0d mm0", i), mm0, tbl[i].e_mm0);
            check($sformatf("tbl%0d mm1", i), mm1, tbl[i].e_mm1);
            check($sformatf("tbl%0d pend", i), pd0, tbl[i].e_pd);
            check($sformatf("tbl%0d unexp", i), un0, tbl[i].e_un);
        end
        check("tbl sticky1", st1, 5'b00111);

        // Depth+1 W beats with port B stalled, then drain Depth matching beats.
        do_reset();
        for (int n = 0; n <= Depth; n++) begin
            clear_inputs();
            av = 5'b00010; ar = 5'b00010;
            apv[1] = (80'(n) << 60) | 80'h1234_5678 + 80'(n);
            step();
            if (n == Depth - 1) check("ovf before full", ov0, 5'b0);
        end
        check("ovf after extra beat", ov0, 5'b00010);
        check("ovf pending", pd0, 5'b00010);
        for (int n = 0; n < Depth; n++) begin
            clear_inputs();
            bv = 5'b00010; br = 5'b00010;
            bpv[1] = (80'(n) << 60) | 80'h1234_5678 + 80'(n);
            step();
            check("drain mismatch", mm0, 5'b0);
        end
        check("drain idle", {4'b0, id0}, 5'b00001);

        // Asynchronous reset with AR beats pending and a sticky flag set.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            clear_inputs();
            av = 5'b01000; ar = 5'b01000;
            apv[3] = base | 80'(n + 1);
            step();
        end
        clear_inputs();
        av = 5'b00100; ar = 5'b00100;
        step();
        check("pre-rst pending", pd0, 5'b01000);
        check("pre-rst sticky", st0, 5'b00100);
        clear_inputs();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async rst pending", pd0, 5'b0);
        check("async rst idle", {4'b0, id0}, 5'b00001);
        check("async rst sticky", st0 | un0 | ov0 | mm0, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Randomized traffic: sink beats mostly replay the expected head,
        // sometimes with a changed ID or a flipped data bit.
        for (int n = 0; n < 1500; n++) begin
            for (int ch = 0; ch < 5; ch++) begin
                av[ch] = ($urandom_range(3, 0) != 0);
                ar[ch] = ($urandom_range(2, 0) != 0);
                bv[ch] = ($urandom_range(3, 0) != 0);
                br[ch] = ($urandom_range(2, 0) != 0);
                r0 = $urandom; r1 = $urandom; r2 = $urandom;
                src = {r2[15:0], r1, r0};
                if (q[5 + ch].size() != 0) snk = q[5 + ch][0];
                else snk = norm(ch, src, 1'b0);
                if (ch != 1 && $urandom_range(7, 0) == 0) snk[3:0] = 4'($urandom);
                if ($urandom_range(19, 0) == 0) snk = snk ^ (80'd1 << $urandom_range(chw(ch) - 1, 0));
                if (ch == 2 || ch == 4) begin
                    bpv[ch] = src;
                    apv[ch] = snk;
                end else begin
                    apv[ch] = src;
                    bpv[ch] = snk;
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
